// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
//   NOP     : instruction word presented when the queue is empty
//   INSTR_W : instruction word width
//   PC_W    : default word-PC width (byte address bits [31:2])
//   clog2   : pointer width for a given depth
package fetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 30;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-unit / decode-stage bundle for the fetch queue.
//   in_valid/in_pc/in_instr : word captured from the fetch unit
//   ifu_stall               : hold the fetch PC (queue full)
//   flush                   : redirect, squash everything
//   out_valid/out_pc/out_instr/out_ready : head entry handshake to decode
//   count                   : current occupancy
// master = fetch/decode side, slave = the queue.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PCW   = fetch_queue_pkg::PC_W
);
    localparam int unsigned CW = fetch_queue_pkg::clog2(DEPTH) + 1;
    localparam int unsigned IW = fetch_queue_pkg::INSTR_W;

    logic          in_valid;
    logic [PCW-1:0] in_pc;
    logic [IW-1:0] in_instr;
    logic          ifu_stall;
    logic          flush;
    logic          out_valid;
    logic [PCW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          out_ready;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  ifu_stall, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output ifu_stall, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/fetch_queue_fq_ptr.sv
// Wrapping pointer register for the fetch queue.
//   clock, rst : clock and synchronous active-high reset
//   inc        : advance by one, wrapping modulo 2**W
//   clr        : return to zero (takes priority over inc)
//   ptr        : current pointer value
module fq_ptr #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next pointer: clear wins, natural overflow gives the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} between fetch and decode.
//   clock, rst : clock and synchronous active-high reset
//   bus        : fetch_queue_if slave (fetch input, decode output, flush, stall, count)
// Outputs are decoded from registered state only; no in_* to out_* path.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PCW   = PC_W
) (
    input  logic          clock,
    input  logic          rst,
    fetch_queue_if.slave  bus
);

    localparam int unsigned PW = clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [PCW-1:0]     pc_mem_q    [DEPTH];
    logic [PCW-1:0]     pc_mem_d    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Occupancy decode and handshake qualification; flush suppresses both moves.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        push  = bus.in_valid & ~full & ~bus.flush;
        pop   = ~empty & bus.out_ready & ~bus.flush;
    end

    fq_ptr #(.W(PW)) u_wr_ptr (
        .clock (clock),
        .rst   (rst),
        .inc   (push),
        .clr   (bus.flush),
        .ptr   (wr_ptr)
    );

    fq_ptr #(.W(PW)) u_rd_ptr (
        .clock (clock),
        .rst   (rst),
        .inc   (pop),
        .clr   (bus.flush),
        .ptr   (rd_ptr)
    );

    // Storage write and occupancy update; flush only resets count, storage keeps stale data.
    always_comb begin
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr]    = bus.in_pc;
            instr_mem_d[wr_ptr] = bus.in_instr;
        end
        if (bus.flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    // Head mux: stale storage is hidden when empty.
    assign bus.out_valid = ~empty;
    assign bus.out_pc    = empty ? '0  : pc_mem_q[rd_ptr];
    assign bus.out_instr = empty ? NOP : instr_mem_q[rd_ptr];
    assign bus.ifu_stall = full;
    assign bus.count     = count_q;

endmodule
